// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between a CPU fetch port and data port.
// Data requests win ties, except when fetch has already waited through MAX_D_RUN data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_D_RUN = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned RUN_W = $clog2(MAX_D_RUN + 1);
    localparam int unsigned TMR_W = 8;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner_d;
    logic [RUN_W-1:0] d_run;
    logic [TMR_W-1:0] timer;
    logic             grant_d_c;

    // Data wins unless fetch is also waiting and the data run limit is reached.
    assign grant_d_c = d_req && !(if_req && (d_run == RUN_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            d_run       <= '0;
            timer       <= '0;
            if_rdata    <= '0;
            if_ack      <= 1'b0;
            d_rdata     <= '0;
            d_ack       <= 1'b0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state   <= BUSY;
                        owner_d <= grant_d_c;
                        mem_cs  <= 1'b1;
                        busy    <= 1'b1;
                        timer   <= '0;
                        if (grant_d_c) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we;
                            if (if_req && (d_run != RUN_MAX)) begin
                                d_run <= d_run + 1'b1;
                            end else if (!if_req) begin
                                d_run <= '0;
                            end
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_we    <= 1'b0;
                            d_run     <= '0;
                        end
                    end
                end

                BUSY: begin
                    timer <= timer + 1'b1;
                    // A completing memory beats a simultaneous timeout.
                    if (mem_ack) begin
                        state  <= RESP;
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else if (timer == TMR_LAST) begin
                        state       <= RESP;
                        mem_cs      <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                        if (owner_d) begin
                            d_rdata <= '0;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: acts as both requesters and the memory,
// checking grants and acks against a scoreboard of expected transactions.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TOUT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          timeout_err;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(4), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;   // memory wait cycles; negative means never ack
        logic [31:0] mdata;
        logic [31:0] rdata;
        int          cs_len;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    exp_t sb[$];
    req_t dq[$];
    req_t iq[$];

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] mdata);
        exp_t e;
        e.is_d   = is_d;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.waits  = waits;
        e.mdata  = mdata;
        e.rdata  = (waits < 0) ? 32'h0 : mdata;
        e.cs_len = (waits < 0) ? int'(TOUT) : waits + 1;
        sb.push_back(e);
        if (is_d) dq.push_back('{we, addr, wdata});
        else      iq.push_back('{1'b0, addr, 32'h0});
    endtask

    // Cycle engine: raises queued requests, plays the memory, checks grants and acks.
    task automatic serve(input int n_acks);
        int   acks = 0;
        int   cyc = 0;
        int   cs_n = 0;
        bit   in_txn = 0;
        bit   drop_d;
        bit   drop_i;
        exp_t cur;
        cur = '{default: 0};
        while (acks < n_acks && cyc < 40 * n_acks) begin
            @(negedge clk);
            cyc++;
            drop_d = 0;
            drop_i = 0;
            chk("busy", busy, mem_cs | if_ack | d_ack);
            if (mem_cs) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cs_n = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk("grant_addr", mem_addr, cur.addr);
                        if (cur.is_d) chk("grant_wdata", mem_wdata, cur.wdata);
                    end
                end
                chk("mem_we", mem_we, cur.we);
                mem_ack   = (cur.waits >= 0) && (cs_n == cur.waits);
                mem_rdata = mem_ack ? cur.mdata : $urandom;
                cs_n++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (if_ack || d_ack) begin
                chk("ack_d_owner", d_ack, cur.is_d);
                chk("ack_if_owner", if_ack, !cur.is_d);
                chk("cs_length", cs_n, cur.cs_len);
                if (cur.is_d) m_d_rdata = cur.rdata;
                else          m_if_rdata = cur.rdata;
                chk("d_rdata", d_rdata, m_d_rdata);
                chk("if_rdata", if_rdata, m_if_rdata);
                if (d_ack) begin d_req = 1'b0; drop_d = 1; end
                if (if_ack) begin if_req = 1'b0; drop_i = 1; end
                in_txn = 0;
                acks++;
            end
            if (!d_req && !drop_d && dq.size() > 0) begin
                req_t r;
                r = dq.pop_front();
                d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
            end
            if (!if_req && !drop_i && iq.size() > 0) begin
                req_t r;
                r = iq.pop_front();
                if_req = 1'b1; if_addr = r.addr;
            end
        end
        chk("serve_acks", acks, n_acks);
    endtask

    initial begin
        reset = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        #3;
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single zero-wait data read
        push_exp(1, 0, 32'h100, 32'h0, 0, 32'hCAFEF00D);
        serve(1);

        // Simultaneous requests: data first, then fetch
        push_exp(1, 0, 32'h40, 32'h0, 1, 32'h11110040);
        push_exp(0, 0, 32'h0, 32'h0, 0, 32'h22220000);
        serve(2);

        // Fetch held against a stream of data: four data grants, fetch, then data wins again
        for (int k = 0; k < 4; k++)
            push_exp(1, k[0], 32'h200 + 32'(4 * k), 32'hD0000000 + 32'(k), k % 2, 32'h33330000 + 32'(k));
        push_exp(0, 0, 32'h1000, 32'h0, 0, 32'h44441000);
        push_exp(1, 0, 32'h210, 32'h0, 0, 32'h33330004);
        push_exp(0, 0, 32'h1004, 32'h0, 2, 32'h44441004);
        serve(7);

        // Write with five memory wait states
        push_exp(1, 1, 32'h20, 32'h12345678, 5, 32'hA5A5A5A5);
        serve(1);
        chk("terr_before_timeout", timeout_err, 0);

        // Memory never answers: abort after TIMEOUT cycles
        push_exp(1, 0, 32'h80, 32'h0, -1, 32'h0);
        serve(1);
        chk("terr_set", timeout_err, 1);
        push_exp(0, 0, 32'h2000, 32'h0, 0, 32'h55552000);
        serve(1);
        chk("terr_sticky", timeout_err, 1);

        // Reset in the middle of a BUSY phase
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int i = 0; i < 10 && !mem_cs; i++) @(negedge clk);
        chk("t6_cs_seen", mem_cs, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_cs_off", mem_cs, 0);
        chk("t6_busy_off", busy, 0);
        chk("t6_terr_clr", timeout_err, 0);
        chk("t6_d_rdata_clr", d_rdata, 0);
        chk("t6_if_rdata_clr", if_rdata, 0);
        m_d_rdata = '0;
        m_if_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_ack", {d_ack, if_ack, mem_cs}, 3'b000);
        end
        d_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_idle_no_ack", {d_ack, if_ack, busy}, 3'b000);
        push_exp(0, 0, 32'h3000, 32'h0, 1, 32'h66663000);
        serve(1);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
